// File: rtl/inst_sram_resp.sv
// Instruction-SRAM responder: byte-lane word memory, one-cycle read-first access,
// side-band preload port, out-of-window flag and saturating access counters.
module inst_sram_lane #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  acc_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] idx_i,
  input  logic [7:0]            wdata_i,
  input  logic                  load_we_i,
  input  logic [ADDR_WIDTH-1:0] load_idx_i,
  input  logic [7:0]            load_data_i,
  input  logic                  rd_clr_i,
  output logic [7:0]            rdata_o
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_q;

  // Contents are deliberately never reset so a preload survives reset.
  always_ff @(posedge clk) begin
    if (we_i)      mem_q[idx_i]      <= wdata_i;
    if (load_we_i) mem_q[load_idx_i] <= load_data_i;
  end

  always_ff @(posedge clk) begin
    if (rd_clr_i)   rd_q <= 8'h00;
    else if (acc_i) rd_q <= mem_q[idx_i];
  end

  assign rdata_o = rd_q;
endmodule

module inst_sram_resp #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE       = 32'hbfc0_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sram_en,
  input  logic [3:0]            sram_wen,
  input  logic [31:0]           sram_addr,
  input  logic [31:0]           sram_wdata,
  output logic [31:0]           sram_rdata,
  output logic                  sram_addr_err,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
);
  localparam int unsigned NUM_LANES = 4;
  localparam logic [32:0] WIN       = 33'd1 << (ADDR_WIDTH + 2);
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  typedef struct packed {
    logic                  acc;
    logic                  clr;
    logic                  coll;
    logic [3:0]            wen;
    logic [ADDR_WIDTH-1:0] idx;
  } req_t;

  logic [31:0] off;
  logic        in_win;
  req_t        req;

  // 33-bit compare keeps the window test correct even when the window spans 4 GiB.
  assign off    = sram_addr - BASE;
  assign in_win = {1'b0, off} < WIN;

  always_comb begin
    req      = '0;
    req.acc  = sram_en & ~reset & in_win;
    req.clr  = reset | (sram_en & ~in_win);
    req.wen  = sram_wen;
    req.idx  = off[ADDR_WIDTH+1:2];
    // A same-word load overrides the whole SRAM write, not just its lanes.
    req.coll = load_en & (load_addr == req.idx);
  end

  logic [NUM_LANES-1:0][7:0] wdata_l, ldata_l, rdata_l;
  assign wdata_l = sram_wdata;
  assign ldata_l = load_data;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    inst_sram_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clk        (clk),
      .acc_i      (req.acc),
      .we_i       (req.acc & req.wen[l] & ~req.coll),
      .idx_i      (req.idx),
      .wdata_i    (wdata_l[l]),
      .load_we_i  (load_en),
      .load_idx_i (load_addr),
      .load_data_i(ldata_l[l]),
      .rd_clr_i   (req.clr),
      .rdata_o    (rdata_l[l])
    );
  end

  assign sram_rdata = rdata_l;

  logic err_q;
  always_ff @(posedge clk) begin
    if (reset)        err_q <= 1'b0;
    else if (sram_en) err_q <= ~in_win;
  end
  assign sram_addr_err = err_q;

  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (sram_en) begin
      if (sram_wen == 4'b0000) begin
        if (rd_cnt_q != CNT_MAX) rd_cnt_d = rd_cnt_q + 32'd1;
      end else begin
        if (wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
endmodule

// File: tb/tb_inst_sram_resp.sv
// Self-checking bench for inst_sram_resp: directed vector table, corner sequences,
// and randomized traffic against a word-array reference model.
module tb_inst_sram_resp;
  localparam logic [31:0] BASE = 32'hbfc0_0000;
  localparam int unsigned DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic        sram_addr_err;
  logic        load_en;
  logic [11:0] load_addr;
  logic [31:0] load_data, rd_count, wr_count;

  inst_sram_resp #(.ADDR_WIDTH(12), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .sram_en(sram_en), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_addr_err(sram_addr_err), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] mem_m [DEPTH];
  logic [31:0] rdata_m, rd_m, wr_m;
  logic        err_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model(input logic rst, input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic ld, input logic [11:0] la, input logic [31:0] ldd);
    logic [31:0] off, w;
    int idx;
    if (rst) begin
      rdata_m = 0; err_m = 0; rd_m = 0; wr_m = 0;
    end else if (en) begin
      off = addr - BASE;
      if (off < 4 * DEPTH) begin
        idx = int'(off / 4);
        w = mem_m[idx];
        rdata_m = w;
        err_m = 0;
        for (int b = 0; b < 4; b++) if (wen[b]) w[8*b +: 8] = wdata[8*b +: 8];
        mem_m[idx] = w;
      end else begin
        rdata_m = 0; err_m = 1;
      end
      if (wen == 0) begin if (rd_m != 32'hFFFF_FFFF) rd_m = rd_m + 1; end
      else begin if (wr_m != 32'hFFFF_FFFF) wr_m = wr_m + 1; end
    end
    if (ld) mem_m[la] = ldd;  // applied last: load wins over a same-word write
  endtask

  task automatic cyc(input logic rst, input logic en, input logic [3:0] wen,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic ld, input logic [11:0] la, input logic [31:0] ldd);
    reset = rst; sram_en = en; sram_wen = wen; sram_addr = addr; sram_wdata = wdata;
    load_en = ld; load_addr = la; load_data = ldd;
    @(posedge clk);
    model(rst, en, wen, addr, wdata, ld, la, ldd);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr);
    cyc(1'b0, 1'b1, 4'h0, addr, 32'h0, 1'b0, 12'h0, 32'h0);
  endtask

  task automatic chk_model(input string name);
    chk({name, ".rdata"}, sram_rdata, rdata_m);
    chk({name, ".err"}, {31'h0, sram_addr_err}, {31'h0, err_m});
  endtask

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
  } vec_t;

  vec_t vt [11];
  logic [11:0] hold_idx [5];
  logic [31:0] w;
  logic [31:0] a;
  logic [11:0] li;

  initial begin
    vt[0]  = '{4'h0, 32'hbfc00000, 32'h0,        32'h11111111, 1'b0, 1, 0};
    vt[1]  = '{4'h0, 32'hbfc00004, 32'h0,        32'h22222222, 1'b0, 2, 0};
    vt[2]  = '{4'h0, 32'hbfc00008, 32'h0,        32'h33333333, 1'b0, 3, 0};
    vt[3]  = '{4'h5, 32'hbfc00004, 32'hAABBCCDD, 32'h22222222, 1'b0, 3, 1};
    vt[4]  = '{4'h0, 32'hbfc00004, 32'h0,        32'h22BB22DD, 1'b0, 4, 1};
    vt[5]  = '{4'h0, 32'hbfc04000, 32'h0,        32'h00000000, 1'b1, 5, 1};
    vt[6]  = '{4'h0, 32'hbfbffffc, 32'h0,        32'h00000000, 1'b1, 6, 1};
    vt[7]  = '{4'h0, 32'hbfc03ffc, 32'h0,        32'h0FF00FF0, 1'b0, 7, 1};
    vt[8]  = '{4'hF, 32'hbfc04000, 32'h5A5A5A5A, 32'h00000000, 1'b1, 7, 2};
    vt[9]  = '{4'h0, 32'hbfc00000, 32'h0,        32'h11111111, 1'b0, 8, 2};
    vt[10] = '{4'h0, 32'hbfc00002, 32'h0,        32'h11111111, 1'b0, 9, 2};

    // preload the whole memory while reset is held
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 12'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      case (i)
        0: w = 32'h11111111;
        1: w = 32'h22222222;
        2: w = 32'h33333333;
        3: w = 32'h44444444;
        4095: w = 32'h0FF00FF0;
        default: w = $urandom;
      endcase
      cyc(1'b1, 1'b0, 4'hF, BASE, 32'hFFFFFFFF, 1'b1, 12'(i), w);
    end
    chk("reset.rdata", sram_rdata, 32'h0);
    chk("reset.err", {31'h0, sram_addr_err}, 32'h0);
    chk("reset.rd_count", rd_count, 32'h0);
    chk("reset.wr_count", wr_count, 32'h0);

    // directed table: fetch, byte write, window edges, ignored low bits
    for (int i = 0; i < 11; i++) begin
      cyc(1'b0, 1'b1, vt[i].wen, vt[i].addr, vt[i].wdata, 1'b0, 12'h0, 32'h0);
      chk($sformatf("vec%0d.rdata", i), sram_rdata, vt[i].exp_rdata);
      chk($sformatf("vec%0d.err", i), {31'h0, sram_addr_err}, {31'h0, vt[i].exp_err});
      chk($sformatf("vec%0d.rd_count", i), rd_count, vt[i].exp_rd);
      chk($sformatf("vec%0d.wr_count", i), wr_count, vt[i].exp_wr);
    end

    // idle cycles hold the response and must not write
    for (int i = 0; i < 5; i++) begin
      hold_idx[i] = 12'($urandom_range(0, DEPTH - 1));
      cyc(1'b0, 1'b0, 4'($urandom_range(1, 15)), BASE + {18'h0, hold_idx[i], 2'b00},
          $urandom, 1'b0, 12'h0, 32'h0);
      chk($sformatf("hold%0d.rdata", i), sram_rdata, 32'h11111111);
      chk($sformatf("hold%0d.err", i), {31'h0, sram_addr_err}, 32'h0);
      chk($sformatf("hold%0d.rd_count", i), rd_count, 32'd9);
      chk($sformatf("hold%0d.wr_count", i), wr_count, 32'd2);
    end
    for (int i = 0; i < 5; i++) begin
      rd(BASE + {18'h0, hold_idx[i], 2'b00});
      chk_model($sformatf("hold_rb%0d", i));
    end

    // load/write collision on word 7, then load/read collision on word 8
    w = mem_m[7];
    cyc(1'b0, 1'b1, 4'hF, 32'hbfc0001c, 32'hFFFFFFFF, 1'b1, 12'd7, 32'h12345678);
    chk("coll_wr.rdata", sram_rdata, w);
    rd(32'hbfc0001c);
    chk("coll_wr.after", sram_rdata, 32'h12345678);
    w = mem_m[8];
    cyc(1'b0, 1'b1, 4'h0, 32'hbfc00020, 32'h0, 1'b1, 12'd8, 32'hCAFEF00D);
    chk("coll_rd.old", sram_rdata, w);
    rd(32'hbfc00020);
    chk("coll_rd.new", sram_rdata, 32'hCAFEF00D);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = BASE + ($urandom_range(0, DEPTH - 1) << 2) + $urandom_range(0, 3);
      li = ($urandom_range(0, 3) == 0) ? 12'((a - BASE) >> 2) : 12'($urandom_range(0, DEPTH - 1));
      cyc(1'b0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15)),
          a, $urandom, $urandom_range(0, 7) == 0, li, $urandom);
      chk_model($sformatf("rand%0d", i));
    end
    chk("rand.rd_count", rd_count, rd_m);
    chk("rand.wr_count", wr_count, wr_m);

    // reset during a write to word 2
    w = mem_m[2];
    cyc(1'b1, 1'b1, 4'hF, 32'hbfc00008, 32'hDEADBEEF, 1'b0, 12'h0, 32'h0);
    chk("rst_mid.rdata", sram_rdata, 32'h0);
    chk("rst_mid.err", {31'h0, sram_addr_err}, 32'h0);
    chk("rst_mid.rd_count", rd_count, 32'h0);
    chk("rst_mid.wr_count", wr_count, 32'h0);
    rd(32'hbfc00008);
    chk("rst_mid.word2", sram_rdata, w);

    // saturation of the read counter
    force dut.rd_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.rd_cnt_q;
    rd_m = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      rd(BASE + (i << 2));
      chk($sformatf("sat%0d.rd_count", i), rd_count, 32'hFFFF_FFFF);
      chk($sformatf("sat%0d.wr_count", i), wr_count, 32'h0);
      chk_model($sformatf("sat%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
